alu_seq: RTL and testbench

Sequential, parametrised successor to the team's single-adder combinational ALU. One shared DW-bit adder serves ADD, SUB and SLT, and also drives an iterative shift-add multiplier. The block adds a start/ready/done handshake, registered results and zero/carry flags. It sits between the operand registers and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: one shared DW-bit adder serves ADD/SUB/SLT and an iterative
// shift-add multiplier, behind a start/ready/done handshake with registered results.
module alu_seq #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   input  logic [2:0]    alu_control,
   output logic          ready,
   output logic          done,
   output logic [DW-1:0] y,
   output logic          zero,
   output logic          carry
);

   localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t          state;
   logic [DW-1:0]   mcand;
   logic [DW-1:0]   mplier;
   logic [DW-1:0]   acc;
   logic [CW-1:0]   cnt;

   logic [DW-1:0]   add_a;
   logic [DW-1:0]   add_b;
   logic            add_cin;
   logic [DW:0]     sum;
   logic            slt;
   logic [DW-1:0]   res;
   logic            res_carry;
   logic [DW-1:0]   acc_next;

   // Shared adder: multiplier accumulate while busy, otherwise the ALU operands
   // (B inverted with carry-in for SUB and SLT).
   always_comb begin
      add_a   = A;
      add_b   = B;
      add_cin = 1'b0;
      if (state == S_MUL) begin
         add_a = acc;
         add_b = mcand;
      end else if (alu_control == OP_SUB || alu_control == OP_SLT) begin
         add_b   = ~B;
         add_cin = 1'b1;
      end
      sum = {1'b0, add_a} + {1'b0, add_b} + (DW+1)'(add_cin);
   end

   // Signed less-than: sign of the difference corrected by signed overflow.
   assign slt      = sum[DW-1] ^ ((A[DW-1] ^ B[DW-1]) & (sum[DW-1] ^ A[DW-1]));
   assign acc_next = mplier[0] ? sum[DW-1:0] : acc;

   // Single-cycle result selection.
   always_comb begin
      res       = '0;
      res_carry = 1'b0;
      case (alu_control)
         OP_ADD, OP_SUB: begin
            res       = sum[DW-1:0];
            res_carry = sum[DW];
         end
         OP_AND:  res = A & B;
         OP_OR:   res = A | B;
         OP_XOR:  res = A ^ B;
         OP_SLT:  res[0] = slt;
         default: res = '0;
      endcase
   end

   // Control state, multiplier datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         y      <= '0;
         zero   <= 1'b1;
         carry  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (alu_control == OP_MUL) begin
                     mcand  <= A;
                     mplier <= B;
                     acc    <= '0;
                     cnt    <= '0;
                     ready  <= 1'b0;
                     state  <= S_MUL;
                  end else begin
                     y     <= res;
                     zero  <= (res == '0);
                     carry <= res_carry;
                     done  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(DW-1)) begin
                  y     <= acc_next;
                  zero  <= (acc_next == '0);
                  carry <= 1'b0;
                  done  <= 1'b1;
                  ready <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of expected completions checked on done,
// plus handshake, latency and reset-abort checks; a DW=8 instance covers the MUL width case.
module tb_alu_seq;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef struct {
      logic [31:0] y;
      logic        zero;
      logic        carry;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [2:0]  alu_control = OP_ADD;
   logic        ready, done, zero, carry;
   logic [31:0] y;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [2:0]  op8 = OP_ADD;
   logic        ready8, done8, zero8, carry8;
   logic [7:0]  y8;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_seq #(.DW(32)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .alu_control(alu_control),
      .ready(ready), .done(done), .y(y), .zero(zero), .carry(carry)
   );

   alu_seq #(.DW(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .alu_control(op8),
      .ready(ready8), .done(done8), .y(y8), .zero(zero8), .carry(carry8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference model: {carry, zero, y}
   function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] wide;
      logic [31:0] r;
      logic        c;
      r = '0;
      c = 1'b0;
      case (op)
         OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
         OP_SUB: begin r = a - b; c = (a >= b); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_MUL: r = a * b;
         default: r = '0;
      endcase
      return {c, (r == 32'd0), r};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [33:0] m;
      exp_t        e;
      start = 1'b1;
      alu_control = op;
      A = a;
      B = b;
      m = model(op, a, b);
      e.y = m[31:0];
      e.zero = m[32];
      e.carry = m[33];
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_y", y, e.y);
            chk("sb_zero", 32'(zero), 32'(e.zero));
            chk("sb_carry", 32'(carry), 32'(e.carry));
         end
      end
   end

   initial begin
      int lat;
      logic [2:0]  ops [9];
      logic [31:0] as  [9];
      logic [31:0] bs  [9];
      ops = '{OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_RSV};
      as  = '{32'hFFFF_FFFF, 32'd0, 32'd5, 32'hFFFF_FFFD, 32'd2,
              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1234_5678};
      bs  = '{32'd1, 32'd5, 32'd5, 32'd2, 32'hFFFF_FFFD,
              32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h9ABC_DEF0};

      // Reset values
      @(posedge clk);
      @(negedge clk);
      chk("rst_y", y, 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // First ADD: one-cycle done, then y holds
      issue(OP_ADD, 32'd10, 32'd20);
      @(negedge clk);
      chk("add_done", 32'(done), 32'd1);
      chk("add_ready", 32'(ready), 32'd1);
      @(negedge clk);
      chk("add_done_low", 32'(done), 32'd0);
      chk("add_y_hold", y, 32'd30);

      // Boundary and bitwise ops, back to back
      for (int i = 0; i < 9; i++) begin
         issue(ops[i], as[i], bs[i]);
         @(negedge clk);
         chk("b2b_done", 32'(done), 32'd1);
      end
      @(negedge clk);
      chk("b2b_done_low", 32'(done), 32'd0);

      // Three consecutive ops: done stays high, y = 2, 5, 3
      issue(OP_ADD, 32'd1, 32'd1);
      @(negedge clk);
      chk("seq1_y", y, 32'd2);
      issue(OP_SUB, 32'd9, 32'd4);
      @(negedge clk);
      chk("seq2_done", 32'(done), 32'd1);
      chk("seq2_y", y, 32'd5);
      issue(OP_OR, 32'd1, 32'd2);
      @(negedge clk);
      chk("seq3_done", 32'(done), 32'd1);
      chk("seq3_y", y, 32'd3);
      @(negedge clk);

      // MUL 7x6 with an ignored ADD request while busy
      issue(OP_MUL, 32'd7, 32'd6);
      lat = 0;
      @(negedge clk);
      while (!done && lat < 40) begin
         chk("mul_busy_ready", 32'(ready), 32'd0);
         if (lat == 5) begin
            start = 1'b1;
            alu_control = OP_ADD;
            A = 32'd1;
            B = 32'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("mul_latency", 32'(lat), 32'd32);
      chk("mul_ready_at_done", 32'(ready), 32'd1);
      chk("mul_y", y, 32'd42);
      @(negedge clk);
      chk("mul_done_low", 32'(done), 32'd0);

      // Reset 10 cycles into MUL 3x3 aborts it
      issue(OP_MUL, 32'd3, 32'd3);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_y", y, 32'd0);
      chk("abort_zero", 32'(zero), 32'd1);
      chk("abort_ready", 32'(ready), 32'd1);
      repeat (40) @(negedge clk);
      issue(OP_ADD, 32'd1, 32'd1);
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd1);
      chk("post_abort_y", y, 32'd2);

      // DW=8: MUL 15x17
      start8 = 1'b1;
      op8 = OP_MUL;
      a8 = 8'd15;
      b8 = 8'd17;
      @(posedge clk);
      #1 start8 = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!done8 && lat < 20) begin
         chk("mul8_busy_ready", 32'(ready8), 32'd0);
         @(negedge clk);
         lat++;
      end
      chk("mul8_latency", 32'(lat), 32'd8);
      chk("mul8_y", 32'(y8), 32'd255);
      chk("mul8_zero", 32'(zero8), 32'd0);
      chk("mul8_carry", 32'(carry8), 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
